// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the core owns the port by default, and a DMA burst
// engine steals idle cycles. A forced DMA beat is taken after MAX_WAIT consecutive lost cycles.
module dm_port_arbiter #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [3:0]          dma_len,
    input  logic [DMD_SIZE-1:0] dma_wdt,
    input  logic [DMD_SIZE-1:0] dm_rd_dt,
    output logic                arb_dm_cslt,
    output logic                arb_dm_wrb,
    output logic [DMA_SIZE-1:0] arb_dm_add,
    output logic [DMD_SIZE-1:0] arb_dm_wdt,
    output logic                arb_stallb,
    output logic                dma_gnt,
    output logic                dma_beat,
    output logic                dma_rvld,
    output logic [DMD_SIZE-1:0] dma_rdt,
    output logic                dma_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [DMA_SIZE-1:0] cur_add, cur_add_nxt;
    logic [3:0]          beats_left, beats_left_nxt;
    logic                dir, dir_nxt;
    logic [3:0]          wait_cnt, wait_cnt_nxt;
    logic                rvld_q, done_q, done_set;
    logic                force_beat;
    logic                core_sel;

    assign force_beat = (wait_cnt == 4'(MAX_WAIT));
    // Outputs are held at their idle values while reset is asserted, whatever the inputs do.
    assign core_sel   = reset & ps_dm_cslt;

    assign dma_rvld = reset & rvld_q;
    assign dma_rdt  = (reset & rvld_q) ? dm_rd_dt : '0;
    assign dma_done = reset & done_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        state_nxt      = state;
        cur_add_nxt    = cur_add;
        beats_left_nxt = beats_left;
        dir_nxt        = dir;
        wait_cnt_nxt   = wait_cnt;
        done_set       = 1'b0;
        dma_gnt        = 1'b0;
        dma_beat       = 1'b0;
        arb_stallb     = 1'b1;
        arb_dm_cslt    = core_sel;
        arb_dm_wrb     = core_sel ? ps_dm_wrb : 1'b1;
        arb_dm_add     = core_sel ? dg_dm_add : '0;
        arb_dm_wdt     = core_sel ? bc_dt : '0;

        if (reset) begin
            case (state)
                IDLE: begin
                    dma_gnt = dma_req;
                    if (dma_req) begin
                        cur_add_nxt    = dma_add;
                        beats_left_nxt = dma_len;
                        dir_nxt        = dma_wrb;
                        wait_cnt_nxt   = 4'd0;
                        state_nxt      = RUN;
                    end
                end
                RUN: begin
                    arb_stallb = ~(ps_dm_cslt & force_beat);
                    if (ps_dm_cslt && !force_beat) begin
                        wait_cnt_nxt = (wait_cnt == 4'hF) ? 4'hF : wait_cnt + 4'd1;
                    end else begin
                        // DMA beat: the port is taken from the core for this cycle.
                        dma_beat     = 1'b1;
                        arb_dm_cslt  = 1'b1;
                        arb_dm_wrb   = dir;
                        arb_dm_add   = cur_add;
                        arb_dm_wdt   = dma_wdt;
                        cur_add_nxt  = cur_add + 1'b1;
                        wait_cnt_nxt = 4'd0;
                        if (beats_left == 4'd0) begin
                            state_nxt = IDLE;
                            done_set  = 1'b1;
                        end else begin
                            beats_left_nxt = beats_left - 4'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, and reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur_add    <= '0;
            beats_left <= 4'd0;
            dir        <= 1'b0;
            wait_cnt   <= 4'd0;
            rvld_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_add    <= cur_add_nxt;
            beats_left <= beats_left_nxt;
            dir        <= dir_nxt;
            wait_cnt   <= wait_cnt_nxt;
            rvld_q     <= dma_beat & dir;
            done_q     <= done_set;
        end
    end

endmodule
